// File: rtl/serial_adder_nbit.sv
// Bit-serial WIDTH-bit unsigned adder. One full-adder slice (two half adders
// plus a carry flip-flop) consumes one operand bit per clock, LSB first.
// A start pulse hands over the operands; done marks a valid sum/c_out.

// Single-bit half adder cell.
module half_adder_1bit (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic c_out_o
);

    assign sum_o   = a_i ^ b_i;
    assign c_out_o = a_i & b_i;

endmodule

module serial_adder_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    // Counter must be at least one bit wide even when WIDTH == 1.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] s_sr_q;
    logic [WIDTH-1:0] s_sr_d;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             carry_d;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;

    logic ha1_sum;
    logic ha1_c;
    logic ha2_sum;
    logic ha2_c;

    // Full-adder slice: HA1 adds the operand bits, HA2 folds in the carry.
    half_adder_1bit u_ha1 (
        .a_i     (a_sr_q[0]),
        .b_i     (b_sr_q[0]),
        .sum_o   (ha1_sum),
        .c_out_o (ha1_c)
    );

    half_adder_1bit u_ha2 (
        .a_i     (ha1_sum),
        .b_i     (carry_q),
        .sum_o   (ha2_sum),
        .c_out_o (ha2_c)
    );

    assign carry_d = ha1_c | ha2_c;

    // The new sum bit enters at the MSB so that after WIDTH shifts bit 0
    // sits at the LSB; a one-bit adder just takes the bit directly.
    if (WIDTH == 1) begin : g_s_sr_w1
        assign s_sr_d = ha2_sum;
    end else begin : g_s_sr_wn
        assign s_sr_d = {ha2_sum, s_sr_q[WIDTH-1:1]};
    end

    // Control FSM, datapath shift registers and registered outputs.
    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of each other, exactly like the flip-flops they model.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        s_sr_q  <= '0;
                        cnt_q   <= '0;
                        carry_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    s_sr_q  <= s_sr_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= s_sr_d;
                        c_out_q <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule
